// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main sequencer of the multi-cycle RV64I core. The block sits between the
// instruction register and the datapath. It fetches instructions over a
// req/ready memory port and decodes the opcode held in IR[6:0]. It then steps
// through the execute, memory and write-back states. In each state it drives
// the datapath mux selects, the write enables and the 2-bit alu_op used by
// alu_control. Illegal opcodes and memory waits that run too long send the
// core to a sticky TRAP state.
//
// Parameters
//   RESET_STATE    state entered on reset; only FETCH (0) is a meaningful value
//   TIMEOUT        number of mem_ready=0 wait cycles allowed in FETCH/LOAD/STORE
//                  before trapping; 0 disables the timeout
//
// Ports
//   clk            in   1  core clock, rising edge
//   rst_n          in   1  asynchronous active-low reset; all outputs 0 while low
//   inst_opcode    in   7  IR[6:0]
//   mem_ready      in   1  memory accepted/completed the current request
//   alu_op         out  2  00 add, 01 sub, 10 funct-derived, 11 branch compare
//   alu_src_a      out  2  0 PC, 1 rs1, 2 old_pc
//   alu_src_b      out  2  0 rs2, 1 immediate, 2 constant 4
//   mem_req        out  1  memory request, held until mem_ready
//   mem_we         out  1  store strobe (qualified by mem_req)
//   iord           out  1  address source: 0 PC, 1 alu_out register
//   ir_write       out  1  latch fetched word into IR and PC into old_pc
//   pc_write       out  1  unconditional PC update
//   pc_write_cond  out  1  PC update when the ALU branch flag is true
//   pc_src         out  1  0 ALU result, 1 alu_out register
//   reg_write      out  1  write rd
//   wb_sel         out  2  0 alu_out, 1 mem data, 2 PC (link), 3 immediate
//   trap           out  1  high in TRAP
//   state          out  4  current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter logic [3:0] RESET_STATE = 4'd0,
   parameter logic [7:0] TIMEOUT     = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] inst_opcode,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_src,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       trap,
   output logic [3:0] state
);

   // ---------------------------------------------------------------------------
   // Encodings
   // ---------------------------------------------------------------------------
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_LOAD     = 4'd5,
      ST_LOAD_WB  = 4'd6,
      ST_STORE    = 4'd7,
      ST_ALU_WB   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR     = 4'd11,
      ST_LUI      = 4'd12,
      ST_AUIPC    = 4'd13,
      ST_TRAP     = 4'd14
   } state_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_BRANCH = 2'b11;

   localparam logic [1:0] SRC_A_PC     = 2'd0;
   localparam logic [1:0] SRC_A_RS1    = 2'd1;
   localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

   localparam logic [1:0] SRC_B_RS2    = 2'd0;
   localparam logic [1:0] SRC_B_IMM    = 2'd1;
   localparam logic [1:0] SRC_B_FOUR   = 2'd2;

   localparam logic [1:0] WB_ALU_OUT = 2'd0;
   localparam logic [1:0] WB_MEM     = 2'd1;
   localparam logic [1:0] WB_LINK    = 2'd2;
   localparam logic [1:0] WB_IMM     = 2'd3;

   // The last permitted wait cycle is the one where the counter already holds
   // TIMEOUT-1. With TIMEOUT=0 the check is disabled, so the counter may wrap.
   localparam bit         TIMEOUT_EN   = (TIMEOUT != 8'd0);
   localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

   // ---------------------------------------------------------------------------
   // State and wait counter
   // ---------------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       timeout_hit;

   assign timeout_hit = TIMEOUT_EN && (wait_q >= TIMEOUT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, whatever order the simulator evaluates them in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= state_e'(RESET_STATE);
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case statement. A path that
   // leaves a signal unassigned would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      wait_d  = 8'd0;            // cleared on any state change
      unique case (state_q)
         ST_FETCH: begin
            if (mem_ready)        state_d = ST_DECODE;
            else if (timeout_hit) state_d = ST_TRAP;
            else                  wait_d  = wait_q + 8'd1;
         end
         ST_DECODE: begin
            unique case (inst_opcode)
               OPC_OP, OPC_OP_32:         state_d = ST_EXEC_R;
               OPC_OP_IMM, OPC_OP_IMM_32: state_d = ST_EXEC_I;
               OPC_LOAD, OPC_STORE:       state_d = ST_MEM_ADDR;
               OPC_BRANCH:                state_d = ST_BRANCH;
               OPC_JAL:                   state_d = ST_JAL;
               OPC_JALR:                  state_d = ST_JALR;
               OPC_LUI:                   state_d = ST_LUI;
               OPC_AUIPC:                 state_d = ST_AUIPC;
               OPC_MISC_MEM:              state_d = ST_FETCH;   // FENCE is a nop
               default:                   state_d = ST_TRAP;
            endcase
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
         // Loads and stores differ only in IR[5].
         ST_MEM_ADDR: state_d = inst_opcode[5] ? ST_STORE : ST_LOAD;
         ST_LOAD: begin
            if (mem_ready)        state_d = ST_LOAD_WB;
            else if (timeout_hit) state_d = ST_TRAP;
            else                  wait_d  = wait_q + 8'd1;
         end
         ST_STORE: begin
            if (mem_ready)        state_d = ST_FETCH;
            else if (timeout_hit) state_d = ST_TRAP;
            else                  wait_d  = wait_q + 8'd1;
         end
         ST_LOAD_WB, ST_ALU_WB, ST_BRANCH, ST_JAL, ST_JALR, ST_LUI, ST_AUIPC:
            state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;   // sticky until reset
         default: state_d = ST_TRAP;   // unused encoding 15
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------------
   // The outputs depend only on the state. The one exception is the FETCH
   // completion strobes, which also depend on mem_ready. All outputs are forced
   // to 0 while rst_n is low, so a pending request drops as soon as reset is
   // asserted and does not wait for a clock edge.
   always_comb begin
      alu_op        = ALU_ADD;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_RS2;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = WB_ALU_OUT;
      trap          = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_a = SRC_A_PC;
               alu_src_b = SRC_B_FOUR;
               alu_op    = ALU_ADD;
               // The IR and PC load only on the cycle the fetch completes.
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               // Precompute the branch/jump target (old_pc + imm) into alu_out.
               alu_src_a = SRC_A_OLD_PC;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_RS2;
               alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_FUNCT;
            end
            ST_MEM_ADDR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
            end
            ST_LOAD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            ST_LOAD_WB: begin
               reg_write = 1'b1;
               wb_sel    = WB_MEM;
            end
            ST_STORE: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            ST_ALU_WB: begin
               reg_write = 1'b1;
               wb_sel    = WB_ALU_OUT;
            end
            ST_BRANCH: begin
               alu_src_a     = SRC_A_RS1;
               alu_src_b     = SRC_B_RS2;
               alu_op        = ALU_BRANCH;
               pc_write_cond = 1'b1;
               pc_src        = 1'b1;   // target computed in DECODE
            end
            ST_JAL: begin
               pc_write  = 1'b1;
               pc_src    = 1'b1;
               reg_write = 1'b1;
               wb_sel    = WB_LINK;
            end
            ST_JALR: begin
               // The datapath clears bit 0 of rs1+imm before loading the PC.
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_ADD;
               pc_write  = 1'b1;
               reg_write = 1'b1;
               wb_sel    = WB_LINK;
            end
            ST_LUI: begin
               reg_write = 1'b1;
               wb_sel    = WB_IMM;
            end
            ST_AUIPC: begin
               // old_pc + imm is already in alu_out from DECODE.
               reg_write = 1'b1;
               wb_sel    = WB_ALU_OUT;
            end
            ST_TRAP: trap = 1'b1;
            default: trap = 1'b1;
         endcase
      end
   end

   assign state = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Scoreboard bench for multicycle_control, built with TIMEOUT=4. For each
// instruction the stimulus side works out the whole state path from the opcode
// and the chosen memory wait counts. It drives one cycle per path step and
// pushes the expected output vector for that step. A separate monitor pops the
// vectors and compares them with the DUT outputs in the middle of the cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int         TO       = 4;
   localparam logic [7:0] TO_PARAM = 8'd4;

   // State numbers as published for the debug port.
   localparam int S_FETCH = 0,  S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3,
                  S_MEM_ADDR = 4, S_LOAD = 5, S_LOAD_WB = 6, S_STORE = 7,
                  S_ALU_WB = 8, S_BRANCH = 9, S_JAL = 10, S_JALR = 11,
                  S_LUI = 12, S_AUIPC = 13, S_TRAP = 14;

   localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_MISC = 7'b0001111,
                          OPC_OPI = 7'b0010011, OPC_AUIPC = 7'b0010111,
                          OPC_OPI32 = 7'b0011011, OPC_STORE = 7'b0100011,
                          OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111,
                          OPC_OP32 = 7'b0111011, OPC_BRANCH = 7'b1100011,
                          OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111;

   typedef struct packed {
      logic [3:0] state;
      logic [1:0] alu_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       trap;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] inst_opcode;
   logic       mem_ready;
   logic [1:0] alu_op, alu_src_a, alu_src_b, wb_sel;
   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
   logic       pc_src, reg_write, trap;
   logic [3:0] state;

   multicycle_control #(.RESET_STATE(4'd0), .TIMEOUT(TO_PARAM)) dut (
      .clk(clk), .rst_n(rst_n), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
      .reg_write(reg_write), .wb_sel(wb_sel), .trap(trap), .state(state)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_pass   = 0;
   obs_t  exp_q[$];
   string tag_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %06h expected %06h", name, act, req);
   endtask

   // Expected outputs for one cycle in state st with mem_ready rdy.
   function automatic obs_t expect_for(input int st, input logic rdy);
      obs_t o = '0;
      o.state = 4'(st);
      case (st)
         S_FETCH:    begin o.mem_req = 1; o.src_b = 2; o.ir_write = rdy; o.pc_write = rdy; end
         S_DECODE:   begin o.src_a = 2; o.src_b = 1; end
         S_EXEC_R:   begin o.src_a = 1; o.alu_op = 2; end
         S_EXEC_I:   begin o.src_a = 1; o.src_b = 1; o.alu_op = 2; end
         S_MEM_ADDR: begin o.src_a = 1; o.src_b = 1; end
         S_LOAD:     begin o.mem_req = 1; o.iord = 1; end
         S_LOAD_WB:  begin o.reg_write = 1; o.wb_sel = 1; end
         S_STORE:    begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
         S_ALU_WB:   o.reg_write = 1;
         S_BRANCH:   begin o.src_a = 1; o.alu_op = 3; o.pc_write_cond = 1; o.pc_src = 1; end
         S_JAL:      begin o.pc_write = 1; o.pc_src = 1; o.reg_write = 1; o.wb_sel = 2; end
         S_JALR:     begin o.src_a = 1; o.src_b = 1; o.pc_write = 1; o.reg_write = 1; o.wb_sel = 2; end
         S_LUI:      begin o.reg_write = 1; o.wb_sel = 3; end
         S_AUIPC:    o.reg_write = 1;
         S_TRAP:     o.trap = 1;
         default:    o = '0;
      endcase
      return o;
   endfunction

   // One clock cycle: inputs change on the falling edge, then the expectation is queued.
   task automatic drive(input logic rst, input logic [6:0] op, input logic rdy,
                        input obs_t e, input string tag);
      @(negedge clk);
      rst_n       = rst;
      inst_opcode = op;
      mem_ready   = rdy;
      #1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic do_reset(input string tag);
      repeat (2) drive(1'b0, 7'($urandom), 1'($urandom), '0, {tag, "/reset"});
   endtask

   // Append n wait cycles plus the completing cycle of a memory state. If n
   // reaches the timeout, the state is held for TO cycles and then TRAP follows.
   function automatic bit add_wait(input int st, input int n, inout int sq[$], inout bit rq[$]);
      if (n >= TO) begin
         repeat (TO) begin sq.push_back(st); rq.push_back(1'b0); end
         sq.push_back(S_TRAP); rq.push_back(1'($urandom));
         return 1'b1;
      end
      repeat (n) begin sq.push_back(st); rq.push_back(1'b0); end
      sq.push_back(st); rq.push_back(1'b1);
      return 1'b0;
   endfunction

   // Run one instruction through the reference sequence and queue expectations.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input string tag);
      int sq[$];
      bit rq[$];
      bit trapped;
      trapped = add_wait(S_FETCH, fw, sq, rq);
      if (!trapped) begin
         sq.push_back(S_DECODE); rq.push_back(1'($urandom));
         case (op)
            OPC_OP, OPC_OP32:  begin sq.push_back(S_EXEC_R); sq.push_back(S_ALU_WB); end
            OPC_OPI, OPC_OPI32: begin sq.push_back(S_EXEC_I); sq.push_back(S_ALU_WB); end
            OPC_LOAD: begin
               sq.push_back(S_MEM_ADDR); rq.push_back(1'($urandom));
               trapped = add_wait(S_LOAD, mw, sq, rq);
               if (!trapped) sq.push_back(S_LOAD_WB);
            end
            OPC_STORE: begin
               sq.push_back(S_MEM_ADDR); rq.push_back(1'($urandom));
               trapped = add_wait(S_STORE, mw, sq, rq);
            end
            OPC_BRANCH: sq.push_back(S_BRANCH);
            OPC_JAL:    sq.push_back(S_JAL);
            OPC_JALR:   sq.push_back(S_JALR);
            OPC_LUI:    sq.push_back(S_LUI);
            OPC_AUIPC:  sq.push_back(S_AUIPC);
            OPC_MISC:   ;
            default:    begin sq.push_back(S_TRAP); trapped = 1'b1; end
         endcase
         // States without a handshake ignore mem_ready, so give them random values.
         while (rq.size() < sq.size()) rq.push_back(1'($urandom));
      end
      if (trapped) begin
         // TRAP must hold for 20 cycles with mem_ready toggling.
         repeat (19) begin sq.push_back(S_TRAP); rq.push_back(1'($urandom)); end
      end
      foreach (sq[i]) begin
         logic [6:0] drv_op;
         // The IR holds stale data while fetching; drive noise there.
         drv_op = (sq[i] == S_FETCH) ? 7'($urandom) : op;
         drive(1'b1, drv_op, rq[i], expect_for(sq[i], rq[i]),
               $sformatf("%s/cyc%0d/st%0d", tag, i, sq[i]));
      end
      if (trapped) do_reset(tag);
   endtask

   function automatic logic [6:0] pick_opcode();
      logic [6:0] legal [12];
      logic [6:0] op;
      bit         hit;
      legal = '{OPC_LOAD, OPC_MISC, OPC_OPI, OPC_AUIPC, OPC_OPI32, OPC_STORE,
                OPC_OP, OPC_LUI, OPC_OP32, OPC_BRANCH, OPC_JALR, OPC_JAL};
      if ($urandom_range(0, 9) != 0) return legal[$urandom_range(0, 11)];
      do begin
         op  = 7'($urandom);
         hit = 1'b0;
         foreach (legal[i]) if (legal[i] == op) hit = 1'b1;
      end while (hit);
      return op;
   endfunction

   function automatic int pick_wait();
      if ($urandom_range(0, 14) == 0) return TO + $urandom_range(0, 2);
      return $urandom_range(0, 3);
   endfunction

   // Monitor: every queued expectation is compared mid-cycle, after the inputs
   // have settled and well clear of the rising edge.
   initial begin : monitor
      obs_t  e, a;
      string t;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{state, alu_op, alu_src_a, alu_src_b, mem_req, mem_we, iord, ir_write,
                  pc_write, pc_write_cond, pc_src, reg_write, wb_sel, trap};
            check(t, 32'(a), 32'(e));
         end
      end
   end

   initial begin : stimulus
      rst_n       = 1'b0;
      inst_opcode = 7'd0;
      mem_ready   = 1'b0;
      do_reset("init");

      run_instr(OPC_OPI,    0, 0, "addi");
      run_instr(OPC_LOAD,   0, 3, "lw_wait3");
      run_instr(OPC_STORE,  0, 0, "sd");
      run_instr(OPC_BRANCH, 0, 0, "beq");
      run_instr(OPC_MISC,   1, 0, "fence");
      run_instr(7'b1111111, 0, 0, "illegal");
      run_instr(OPC_OPI,    TO, 0, "fetch_timeout");
      run_instr(OPC_STORE,  0, TO, "store_timeout");
      run_instr(OPC_OP,     TO - 1, 0, "fetch_max_wait");

      // Reset in the middle of a waiting fetch: mem_req must drop right away,
      // and the next fetch must start with a fresh wait budget.
      drive(1'b1, 7'($urandom), 1'b0, expect_for(S_FETCH, 1'b0), "midrst/f0");
      drive(1'b1, 7'($urandom), 1'b0, expect_for(S_FETCH, 1'b0), "midrst/f1");
      drive(1'b1, 7'($urandom), 1'b0, expect_for(S_FETCH, 1'b0), "midrst/f2");
      do_reset("midrst");
      run_instr(OPC_JAL, TO - 1, 0, "after_midrst");

      for (int n = 0; n < 300; n++)
         run_instr(pick_opcode(), pick_wait(), pick_wait(), $sformatf("rand%0d", n));

      repeat (3) @(negedge clk);
      #3;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
